// File: rtl/obi_sbr_rready_adapter_pkg.sv
// Shared helpers for the rready adapter: reservation-counter sizing.
package obi_sbr_rready_adapter_pkg;

    // Counter must hold every value 0..depth inclusive.
    function automatic int unsigned rsv_width(input int unsigned depth);
        return (depth < 32'd1) ? 32'd1 : $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/obi_sbr_rready_adapter_fifo.sv
// Stream FIFO with optional fall-through bypass; holds device responses until
// the manager accepts them.
module obi_sbr_rready_adapter_fifo #(
    parameter bit          FALL_THROUGH = 1'b1,
    parameter int unsigned DEPTH        = 2,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic testmode_i,
    input  dtype data_i,
    input  logic valid_i,
    output logic ready_o,
    output dtype data_o,
    output logic valid_o,
    input  logic ready_i
);

    localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam int unsigned CW = $clog2(DEPTH + 32'd1);

    dtype          r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_store;
    logic w_deq;
    logic w_flush;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 32'd1)) ? '0 : p + AW'(1);
    endfunction

    // Flush is ignored during scan test so patterns fully own the state.
    assign w_flush  = flush_i & ~testmode_i;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CW'(DEPTH));
    assign w_bypass = FALL_THROUGH & w_empty;
    assign valid_o  = ~w_empty | (w_bypass & valid_i);
    assign data_o   = w_bypass ? data_i : r_mem[r_rd];
    assign ready_o  = ~w_full;
    // A bypassed word taken in the same cycle never lands in storage.
    assign w_store  = valid_i & ~w_full & ~(w_bypass & ready_i);
    assign w_deq    = ready_i & ~w_empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_store) begin
                r_mem[r_wr] <= data_i;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_deq) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_store, w_deq})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/obi_sbr_rready_adapter.sv
// OBI subordinate adapter: reserves a FIFO slot per granted request so a
// fixed-latency device can serve an rready-driving manager.
// Optional SVA checks are compiled when OBI_SBR_RREADY_ADAPTER_ASSERT_EN is defined.
module obi_sbr_rready_adapter
    import obi_sbr_rready_adapter_pkg::*;
#(
    parameter type         obi_a_chan_t = logic,
    parameter type         obi_r_chan_t = logic,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned Latency      = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        test_mode_i,
    input  obi_a_chan_t sbr_a_chan_i,
    input  logic        req_i,
    output logic        gnt_o,
    output obi_r_chan_t sbr_r_chan_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output obi_a_chan_t mem_a_chan_o,
    output logic        mem_req_o,
    input  obi_r_chan_t mem_r_chan_i
);

    localparam int unsigned RsvW = rsv_width(DEPTH);

    logic [RsvW-1:0]    r_rsv;
    logic [Latency-1:0] r_lat;

    logic w_free;
    logic w_gnt;
    logic w_mem_req;
    logic w_push;
    logic w_fifo_ready;
    logic w_rvalid;

    assign w_free    = w_rvalid & rready_i;
    // A response leaving this cycle frees a slot for a new grant.
    assign w_gnt     = (r_rsv < RsvW'(DEPTH)) | w_free;
    assign w_mem_req = req_i & w_gnt;
    assign w_push    = r_lat[Latency-1];

    assign gnt_o        = w_gnt;
    assign mem_req_o    = w_mem_req;
    assign mem_a_chan_o = sbr_a_chan_i;
    assign rvalid_o     = w_rvalid;

    // Reservation counter: responses in flight or buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsv <= '0;
        end else begin
            case ({w_mem_req, w_free})
                2'b10:   r_rsv <= r_rsv + RsvW'(1);
                2'b01:   r_rsv <= r_rsv - RsvW'(1);
                default: r_rsv <= r_rsv;
            endcase
        end
    end

    // Latency tracker: top bit marks the device response as valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lat <= '0;
        end else begin
            r_lat[0] <= w_mem_req;
            for (int i = 1; i < int'(Latency); i++) begin
                r_lat[i] <= r_lat[i-1];
            end
        end
    end

    obi_sbr_rready_adapter_fifo #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (DEPTH),
        .dtype        (obi_r_chan_t)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (test_mode_i),
        .data_i     (mem_r_chan_i),
        .valid_i    (w_push),
        .ready_o    (w_fifo_ready),
        .data_o     (sbr_r_chan_o),
        .valid_o    (w_rvalid),
        .ready_i    (rready_i)
    );

`ifdef OBI_SBR_RREADY_ADAPTER_ASSERT_EN
    if (DEPTH < 32'd1 || Latency < 32'd1) begin : g_bad_params
        $error("obi_sbr_rready_adapter: DEPTH and Latency must both be >= 1");
    end

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_push |-> w_fifo_ready);
    a_rsv_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_rsv <= RsvW'(DEPTH));
    a_no_free_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_free |-> (r_rsv != '0));
    a_r_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_rvalid & ~rready_i) |=> (w_rvalid && $stable(sbr_r_chan_o)));
`endif

endmodule
